cordic_phase_detector: RTL
==========================

# cordic_phase_detector

Iterative CORDIC vectoring block that recovers the phase, and an uncompensated magnitude, of a sine/cosine sample pair. It is the inverse of the DDS phase-to-amplitude path: its phase output uses the same unsigned full-circle encoding, where 2^PHASE_DW corresponds to 2π. It is used for phase-recovery loops and as a round-trip checker behind the DDS. It has AXI-stream-style valid/ready on both sides and processes one sample at a time.

## Interface
- IN_DW, 16: signed width of the sin/cos inputs.
- PHASE_DW, 16: phase output width (unsigned, 0 = 0 rad, 2^(PHASE_DW-1) = π).
- ITERATIONS, 14: CORDIC micro-rotations per sample; legal range 4..PHASE_DW.
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- s_axis_in_sin_tdata  in  IN_DW  signed y component.
- s_axis_in_cos_tdata  in  IN_DW  signed x component.
- s_axis_in_tvalid  in  1  input sample valid.
- s_axis_in_tready  out  1  block can accept a sample.
- m_axis_phase_tdata  out  PHASE_DW  unsigned phase, atan2(sin, cos) mod 2π.
- m_axis_mag_tdata  out  IN_DW+1  unsigned magnitude × CORDIC gain (≈1.6468), not compensated.
- m_axis_out_tvalid  out  1  phase and magnitude valid.
- m_axis_out_tready  in  1  downstream accepts the result.

## Operation
- FSM states:
  - IDLE: s_axis_in_tready=1.
  - ITER: counter i runs 0..ITERATIONS-1.
  - DONE: m_axis_out_tvalid=1.
- IDLE→ITER on s_axis_in_tvalid && s_axis_in_tready. On that edge, register the pre-rotated values, with x and y sign-extended to IN_DW+2 bits:
  - if cos<0: x=-cos, y=-sin, z=2^(PHASE_DW-1);
  - else: x=cos, y=sin, z=0.
- ITER, one micro-rotation per cycle, arithmetic shift by i:
  - if y≥0: x+=y>>>i, y-=x>>>i, z+=ATAN[i];
  - else: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
  - Both updates use the pre-update x and y.
  - z is PHASE_DW bits and wraps modulo 2^PHASE_DW.
- ATAN[i] = round(atan(2^-i) · 2^PHASE_DW / 2π), computed at elaboration. ATAN[0] = 2^(PHASE_DW-3).
- ITER→DONE on the edge that performs iteration ITERATIONS-1. On the same edge: m_axis_phase_tdata←z_final and m_axis_mag_tdata←x_final[IN_DW:0]. x_final is always ≥0 and <2^(IN_DW+1).
- Zero input (sin=0 and cos=0): a flag is latched at acceptance. Outputs are phase=0 and mag=0, with the same latency and handshake as normal samples.
- DONE→IDLE on m_axis_out_tready=1.
  - m_axis_out_tvalid deasserts on that edge.
  - Output data holds its last value until overwritten.
- No input is accepted outside IDLE. Upstream must hold s_axis_in_tvalid and its data stable until accepted.

## Timing
- Reset (reset_n=0 sampled on an edge):
  - state←IDLE;
  - m_axis_phase_tdata=0, m_axis_mag_tdata=0, m_axis_out_tvalid=0;
  - internal x, y, z, counter and zero flag cleared;
  - s_axis_in_tready=0 while reset_n is low.
- Reset mid-operation (ITER or DONE): the sample in progress is discarded; no tvalid pulse is produced for it.
- Latency: m_axis_out_tvalid is high exactly ITERATIONS cycles after the acceptance edge.
- Back-to-back throughput, m_axis_out_tready held 1: one sample per ITERATIONS+2 cycles (acceptance, ITERATIONS iterations, output handshake).
- In DONE with m_axis_out_tready=0: tvalid, phase and mag stay constant and s_axis_in_tready stays 0, indefinitely.
- s_axis_in_tready is a function of state and reset_n only, never of s_axis_in_tvalid.
- Accuracy (default parameters): |phase error| ≤ 4 LSB for input magnitude ≥ 2^(IN_DW-3). Mag is within 1% of 1.6468·√(sin²+cos²).

## Test plan
- Cardinal points, defaults: (sin,cos)=(0,32767)→phase 0±4, mag 53961±540; (32767,0)→16384±4; (0,-32768)→32768±4; (-32767,0)→49152±4. Each has tvalid exactly 14 cycles after acceptance.
- Diagonal and wrap case: (-23170,23170)→57344±4; (-1,32767)→65535 or near 0 with modular error ≤4. Checks z wrap-around.
- Zero input: (0,0)→phase 0, mag 0, tvalid after 14 cycles.
- Backpressure: hold m_axis_out_tready=0 for 20 cycles after tvalid. Outputs stable, s_axis_in_tready=0 throughout, and a second offered sample is not accepted until 1 cycle after the output handshake.
- Reset mid-ITER: assert reset_n=0 for 1 cycle at iteration 5. All outputs are 0, no tvalid pulse follows, and s_axis_in_tready=1 on the first cycle after release.
- Round trip: feed DDS sin/cos for phases 0..65535 step 97 (SIN_COS=1). Recovered phase equals the input phase within ±4 LSB modulo 2^16; streaming period is 16 cycles.

Source files
------------

// File: rtl/cordic_phase_detector.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_phase_detector
//  Description : Iterative CORDIC vectoring engine. Recovers atan2(sin, cos)
//                as an unsigned full-circle phase (2^PHASE_DW == 2*pi) and
//                the uncompensated magnitude (gain ~1.6468) of one sample at
//                a time, with valid/ready handshakes on both sides.
//  Ports       :
//    clk                  in   single clock, rising edge
//    reset_n              in   synchronous active-low reset
//    s_axis_in_sin_tdata  in   signed y component  [IN_DW]
//    s_axis_in_cos_tdata  in   signed x component  [IN_DW]
//    s_axis_in_tvalid     in   input sample valid
//    s_axis_in_tready     out  block can accept a sample (IDLE only)
//    m_axis_phase_tdata   out  unsigned phase      [PHASE_DW]
//    m_axis_mag_tdata     out  magnitude * gain    [IN_DW+1]
//    m_axis_out_tvalid    out  phase/magnitude valid
//    m_axis_out_tready    in   downstream accepts the result
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_phase_detector #(
    parameter int IN_DW      = 16,
    parameter int PHASE_DW   = 16,
    parameter int ITERATIONS = 14
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IN_DW-1:0]     s_axis_in_sin_tdata,
    input  logic [IN_DW-1:0]     s_axis_in_cos_tdata,
    input  logic                 s_axis_in_tvalid,
    output logic                 s_axis_in_tready,
    output logic [PHASE_DW-1:0]  m_axis_phase_tdata,
    output logic [IN_DW:0]       m_axis_mag_tdata,
    output logic                 m_axis_out_tvalid,
    input  logic                 m_axis_out_tready
);

    // Two guard bits: one for the CORDIC gain growth, one for the sign.
    localparam int c_XW    = IN_DW + 2;
    localparam int c_CW    = $clog2(ITERATIONS);
    localparam int c_DEPTH = 2 ** c_CW;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [c_CW-1:0]     c_LAST = c_CW'(ITERATIONS - 1);
    localparam logic [PHASE_DW-1:0] c_HALF = {1'b1, {(PHASE_DW-1){1'b0}}};
    localparam real                 c_PI   = 3.14159265358979323846;

    // Arctangent table entry in phase LSBs, evaluated at elaboration only.
    function automatic logic [PHASE_DW-1:0] atan_entry(input int idx);
        real r;
        if (idx == 0) begin
            return c_HALF >> 2;
        end
        r = $atan(1.0 / (2.0 ** idx)) * (2.0 ** PHASE_DW) / (2.0 * c_PI);
        return PHASE_DW'($rtoi(r + 0.5));
    endfunction

    logic [PHASE_DW-1:0] w_atan [c_DEPTH];

    // Table padded to a power of two so any counter value indexes a
    // defined entry; the padding is never reached in normal operation.
    generate
        for (genvar g = 0; g < c_DEPTH; g++) begin : g_atan
            if (g < ITERATIONS) begin : g_entry
                localparam logic [PHASE_DW-1:0] c_VAL = atan_entry(g);
                assign w_atan[g] = c_VAL;
            end else begin : g_pad
                assign w_atan[g] = '0;
            end
        end
    endgenerate

    logic [1:0]               r_state_q, w_state_d;
    logic [c_CW-1:0]          r_iter_q,  w_iter_d;
    logic signed [c_XW-1:0]   r_x_q,     w_x_d;
    logic signed [c_XW-1:0]   r_y_q,     w_y_d;
    logic [PHASE_DW-1:0]      r_z_q,     w_z_d;
    logic                     r_zero_q,  w_zero_d;
    logic [PHASE_DW-1:0]      r_phase_q, w_phase_d;
    logic [IN_DW:0]           r_mag_q,   w_mag_d;
    logic                     r_valid_q, w_valid_d;

    logic signed [c_XW-1:0]   w_sin_ext, w_cos_ext;
    logic signed [c_XW-1:0]   w_x_shr, w_y_shr;
    logic signed [c_XW-1:0]   w_x_rot, w_y_rot;
    logic [PHASE_DW-1:0]      w_z_rot;

    assign s_axis_in_tready   = reset_n && (r_state_q == c_IDLE);
    assign m_axis_phase_tdata = r_phase_q;
    assign m_axis_mag_tdata   = r_mag_q;
    assign m_axis_out_tvalid  = r_valid_q;

    always_comb begin
        w_sin_ext = {{2{s_axis_in_sin_tdata[IN_DW-1]}}, s_axis_in_sin_tdata};
        w_cos_ext = {{2{s_axis_in_cos_tdata[IN_DW-1]}}, s_axis_in_cos_tdata};

        // One micro-rotation driving y toward zero; both updates use the
        // pre-update x and y.
        w_x_shr = r_x_q >>> r_iter_q;
        w_y_shr = r_y_q >>> r_iter_q;
        if (!r_y_q[c_XW-1]) begin
            w_x_rot = r_x_q + w_y_shr;
            w_y_rot = r_y_q - w_x_shr;
            w_z_rot = r_z_q + w_atan[r_iter_q];
        end else begin
            w_x_rot = r_x_q - w_y_shr;
            w_y_rot = r_y_q + w_x_shr;
            w_z_rot = r_z_q - w_atan[r_iter_q];
        end

        w_state_d = r_state_q;
        w_iter_d  = r_iter_q;
        w_x_d     = r_x_q;
        w_y_d     = r_y_q;
        w_z_d     = r_z_q;
        w_zero_d  = r_zero_q;
        w_phase_d = r_phase_q;
        w_mag_d   = r_mag_q;
        w_valid_d = r_valid_q;

        case (r_state_q)
            c_IDLE: begin
                if (s_axis_in_tvalid) begin
                    // Left half-plane samples are rotated by pi first so the
                    // iterations only need to cover +/- 90 degrees.
                    if (w_cos_ext[c_XW-1]) begin
                        w_x_d = -w_cos_ext;
                        w_y_d = -w_sin_ext;
                        w_z_d = c_HALF;
                    end else begin
                        w_x_d = w_cos_ext;
                        w_y_d = w_sin_ext;
                        w_z_d = '0;
                    end
                    w_zero_d  = (s_axis_in_sin_tdata == '0) &&
                                (s_axis_in_cos_tdata == '0);
                    w_iter_d  = '0;
                    w_state_d = c_ITER;
                end
            end
            c_ITER: begin
                w_x_d    = w_x_rot;
                w_y_d    = w_y_rot;
                w_z_d    = w_z_rot;
                w_iter_d = r_iter_q + c_CW'(1);
                if (r_iter_q == c_LAST) begin
                    w_state_d = c_DONE;
                    w_valid_d = 1'b1;
                    // A zero vector has no defined angle; report 0/0.
                    w_phase_d = r_zero_q ? '0 : w_z_rot;
                    w_mag_d   = r_zero_q ? '0 : w_x_rot[IN_DW:0];
                end
            end
            c_DONE: begin
                if (m_axis_out_tready) begin
                    w_state_d = c_IDLE;
                    w_valid_d = 1'b0;
                end
            end
            default: begin
                w_state_d = c_IDLE;
                w_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q <= c_IDLE;
            r_iter_q  <= '0;
            r_x_q     <= '0;
            r_y_q     <= '0;
            r_z_q     <= '0;
            r_zero_q  <= 1'b0;
            r_phase_q <= '0;
            r_mag_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_iter_q  <= w_iter_d;
            r_x_q     <= w_x_d;
            r_y_q     <= w_y_d;
            r_z_q     <= w_z_d;
            r_zero_q  <= w_zero_d;
            r_phase_q <= w_phase_d;
            r_mag_q   <= w_mag_d;
            r_valid_q <= w_valid_d;
        end
    end

endmodule
`default_nettype wire
